// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: datapath widths and the
// MEM-stage access FSM state encoding.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the two control bits and holds
// the data fields; otherwise a load captures every field.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [WORD_W-1:0]     read_data_in,
  input  logic [WORD_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  output logic [WORD_W-1:0]     read_data_out,
  output logic [WORD_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_out  <= '0;
      alu_result_out <= '0;
      write_reg_out  <= '0;
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
    end else if (bubble) begin
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
    end else if (load) begin
      read_data_out  <= read_data_in;
      alu_result_out <= alu_result_in;
      write_reg_out  <= write_reg_in;
      mem_to_reg_out <= mem_to_reg_in;
      reg_write_out  <= reg_write_in;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: stalls the pipeline around a data-memory access,
// runs the req/ready handshake, resolves branches and drives MEM/WB.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int                TIMEOUT  = 16,
  parameter logic [WORD_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     branch_target,
  input  logic                  zero,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic [WORD_W-1:0]     read_data_2,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  mem_to_reg,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch,
  output logic                  hit,
  output logic                  pc_src,
  output logic [WORD_W-1:0]     branch_target_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [WORD_W-1:0]     mem_rdata,
  output logic [WORD_W-1:0]     read_data_out,
  output logic [WORD_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                mem_op;
  logic                misaligned;
  logic                start_access;
  logic                timed_out;
  logic [WORD_W-1:0]   wb_read_data;
  logic                wb_reg_write;

  assign mem_op       = mem_read | mem_write;
  assign misaligned   = (alu_result[1:0] != 2'b00);
  assign start_access = (state_q == MS_IDLE) && mem_op && !misaligned;
  assign timed_out    = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    hit = 1'b1;
    case (state_q)
      MS_IDLE: hit = !start_access;
      MS_WAIT: hit = 1'b0;
      MS_DONE: hit = 1'b1;
      default: hit = 1'b1;
    endcase
  end

  assign pc_src            = branch & zero & hit;
  assign branch_target_out = branch_target;

  // A faulted access (misaligned in IDLE, timeout recorded in err_q) must not write the register file.
  always_comb begin
    wb_read_data = '0;
    wb_reg_write = reg_write;
    if (state_q == MS_DONE) begin
      wb_read_data = rdata_q;
      wb_reg_write = reg_write & !err_q;
    end else if (mem_op && misaligned) begin
      wb_reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MS_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          cnt_q <= '0;
          if (start_access) begin
            state_q   <= MS_WAIT;
            err_q     <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= mem_write;
            mem_addr  <= alu_result;
            mem_wdata <= read_data_2;
          end else if (mem_op && misaligned) begin
            bus_err <= 1'b1;
          end
        end
        MS_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A ready arriving on the expiry cycle still completes cleanly.
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state_q <= MS_DONE;
          end else if (timed_out) begin
            rdata_q <= ERR_DATA;
            bus_err <= 1'b1;
            err_q   <= 1'b1;
            mem_req <= 1'b0;
            state_q <= MS_DONE;
          end
        end
        MS_DONE: begin
          cnt_q   <= '0;
          state_q <= MS_IDLE;
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk            (clk),
    .reset          (reset),
    .load           (hit),
    .bubble         (!hit),
    .read_data_in   (wb_read_data),
    .alu_result_in  (alu_result),
    .write_reg_in   (write_reg),
    .mem_to_reg_in  (mem_to_reg),
    .reg_write_in   (wb_reg_write),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .write_reg_out  (write_reg_out),
    .mem_to_reg_out (mem_to_reg_out),
    .reg_write_out  (reg_write_out)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, branch, loads and
// stores with various memory latencies, timeout, misalignment and reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] branch_target;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] read_data_2;
  logic [4:0]  write_reg;
  logic        mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic        hit, pc_src;
  logic [31:0] branch_target_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;
  logic        mem_to_reg_out, reg_write_out, bus_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int stalls, req_cycles;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset), .branch_target(branch_target), .zero(zero),
    .alu_result(alu_result), .read_data_2(read_data_2), .write_reg(write_reg),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .hit(hit), .pc_src(pc_src),
    .branch_target_out(branch_target_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop();
    branch_target = '0; zero = 1'b0; alu_result = '0; read_data_2 = '0;
    write_reg = '0; mem_to_reg = 1'b0; reg_write = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
  endtask

  // Memory model: asserts ready k cycles after mem_req is first seen (k<0: never).
  task automatic run_mem(input int k, input logic [31:0] rdata,
                         output int n_stall, output int n_req);
    int wc;
    n_stall = 0; n_req = 0; wc = 0;
    for (int i = 0; i < 40 && hit === 1'b0; i++) begin
      n_stall++;
      if (mem_req === 1'b1) begin
        n_req++;
        if (wc == k) begin
          mem_ready = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        end
        wc++;
      end
      tick();
      mem_ready = 1'b0;
      #1;
    end
    chk("stall_bound", {31'd0, hit}, 32'd1);
  endtask

  initial begin
    nop();
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_hit", {31'd0, hit}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_read_data", read_data_out, 32'd0);
    chk("rst_reg_write", {31'd0, reg_write_out}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);

    // ALU op; mem_ready outside WAIT is ignored
    reg_write = 1'b1; alu_result = 32'hAA001122; write_reg = 5'd8;
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    chk("alu_hit", {31'd0, hit}, 32'd1);
    tick();
    mem_ready = 1'b0;
    exp_q.push_back(32'd0);
    chk("alu_result_out", alu_result_out, 32'hAA001122);
    chk("alu_write_reg", {27'd0, write_reg_out}, 32'd8);
    chk("alu_reg_write", {31'd0, reg_write_out}, 32'd1);
    chk("alu_read_data", read_data_out, exp_q.pop_front());
    chk("alu_no_req", {31'd0, mem_req}, 32'd0);

    // Branch resolution
    nop(); branch = 1'b1; zero = 1'b1; branch_target = 32'h4;
    #1;
    chk("br_pc_src", {31'd0, pc_src}, 32'd1);
    chk("br_target", branch_target_out, 32'h4);
    zero = 1'b0;
    #1;
    chk("br_not_taken", {31'd0, pc_src}, 32'd0);
    tick();

    // Load at 0x10, ready 3 cycles after mem_req
    nop(); mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
    alu_result = 32'h10; write_reg = 5'd9;
    #1;
    chk("ld_hit_comb", {31'd0, hit}, 32'd0);
    exp_q.push_back(32'h12345678);
    run_mem(3, 32'h12345678, stalls, req_cycles);
    chk("ld_stalls", stalls, 32'd5);
    chk("ld_req_cycles", req_cycles, 32'd4);
    chk("ld_req_dropped", {31'd0, mem_req}, 32'd0);
    chk("ld_addr", mem_addr, 32'h10);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    chk("ld_bubble_rw", {31'd0, reg_write_out}, 32'd0);
    tick();
    nop();
    chk("ld_read_data", read_data_out, exp_q.pop_front());
    chk("ld_mem_to_reg", {31'd0, mem_to_reg_out}, 32'd1);
    chk("ld_reg_write", {31'd0, reg_write_out}, 32'd1);
    chk("ld_write_reg", {27'd0, write_reg_out}, 32'd9);

    // Store, zero-wait memory
    mem_write = 1'b1; alu_result = 32'h20; read_data_2 = 32'hCAFEF00D;
    #1;
    run_mem(0, 32'h0, stalls, req_cycles);
    chk("st_stalls", stalls, 32'd2);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'hCAFEF00D);
    chk("st_addr", mem_addr, 32'h20);
    tick();
    nop();
    chk("st_reg_write", {31'd0, reg_write_out}, 32'd0);
    chk("st_no_err", {31'd0, bus_err}, 32'd0);

    // Misaligned load at 0x6
    mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
    alu_result = 32'h6; write_reg = 5'd3;
    #1;
    chk("mis_hit", {31'd0, hit}, 32'd1);
    tick();
    nop();
    #1;
    chk("mis_no_req", {31'd0, mem_req}, 32'd0);
    chk("mis_bus_err", {31'd0, bus_err}, 32'd1);
    chk("mis_reg_write", {31'd0, reg_write_out}, 32'd0);
    chk("mis_alu_out", alu_result_out, 32'h6);
    tick();
    chk("mis_sticky", {31'd0, bus_err}, 32'd1);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_clears_err", {31'd0, bus_err}, 32'd0);

    // Ready on the expiry cycle wins
    mem_read = 1'b1; reg_write = 1'b1; alu_result = 32'h30; write_reg = 5'd4;
    #1;
    run_mem(15, 32'h0BADF00D, stalls, req_cycles);
    chk("edge_stalls", stalls, 32'd17);
    chk("edge_no_err", {31'd0, bus_err}, 32'd0);
    tick();
    nop();
    chk("edge_read_data", read_data_out, 32'h0BADF00D);
    chk("edge_reg_write", {31'd0, reg_write_out}, 32'd1);

    // Timeout: never ready
    mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
    alu_result = 32'h44; write_reg = 5'd7;
    #1;
    run_mem(-1, 32'h0, stalls, req_cycles);
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_stalls", stalls, 32'd17);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_req_dropped", {31'd0, mem_req}, 32'd0);
    tick();
    nop();
    chk("to_read_data", read_data_out, 32'hDEADBEEF);
    chk("to_reg_write", {31'd0, reg_write_out}, 32'd0);
    chk("to_mem_to_reg", {31'd0, mem_to_reg_out}, 32'd1);
    tick();

    // Reset pulse during WAIT
    mem_read = 1'b1; reg_write = 1'b1; alu_result = 32'h40; write_reg = 5'd5;
    tick();
    chk("rw_req", {31'd0, mem_req}, 32'd1);
    chk("rw_addr", mem_addr, 32'h40);
    nop(); reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rw_req_cleared", {31'd0, mem_req}, 32'd0);
    chk("rw_addr_cleared", mem_addr, 32'd0);
    chk("rw_hit", {31'd0, hit}, 32'd1);
    chk("rw_read_data", read_data_out, 32'd0);
    chk("rw_alu_out", alu_result_out, 32'd0);
    chk("rw_bus_err", {31'd0, bus_err}, 32'd0);
    tick();
    chk("rw_idle_no_req", {31'd0, mem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
